// File: rtl/iir_power_meter.sv
`default_nettype none
// ============================================================================
//  Module   : iir_power_meter
//  Purpose  : Block-averaged |y|^2 power meter for the filtered I/Q stream.
//             Squares each complex sample and averages 2^Log2Navg of them.
//             Tracks the peak block power, and the tag of that block, over a
//             frequency sweep. Reports the peak when the sweep tag wraps.
//  Ports    : clk, resetn       - clock / asynchronous active-low reset
//             dv_in             - one-cycle strobe per input sample
//             d_real, d_imag    - signed filtered sample
//             tag_in            - sweep tag, sampled with dv_in
//             dv_out            - pulse: p_out / p_tag valid
//             p_out, p_tag      - block-mean power and tag of the block's 1st sample
//             peak_valid        - pulse at sweep wrap with the previous sweep's peak
//             peak_out/peak_tag - largest block power of the sweep and its tag
//  Revision : 1.0  initial release
// ============================================================================
module iir_power_meter #(
  parameter int Nwidth   = 18,
  parameter int Log2Navg = 10,
  parameter int Ntag     = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     dv_in,
  input  logic signed [Nwidth-1:0] d_real,
  input  logic signed [Nwidth-1:0] d_imag,
  input  logic [Ntag-1:0]          tag_in,
  output logic                     dv_out,
  output logic [2*Nwidth-1:0]      p_out,
  output logic [Ntag-1:0]          p_tag,
  output logic                     peak_valid,
  output logic [2*Nwidth-1:0]      peak_out,
  output logic [Ntag-1:0]          peak_tag
);

  localparam int SQ_W  = 2*Nwidth-1;
  localparam int PWR_W = 2*Nwidth;
  localparam int ACC_W = 2*Nwidth + Log2Navg;

  typedef enum logic [0:0] {
    S_FIRST = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  // ---------------------------------------------------------------- stage 1
  // A square of a signed value is never negative and is at most
  // 2^(2*Nwidth-2), so the product fits in 2*Nwidth-1 unsigned bits.
  logic [SQ_W-1:0]  sq_re_d, sq_im_d, sq_re_q, sq_im_q;
  logic             dv1_q;
  logic [Ntag-1:0]  tag1_q;

  assign sq_re_d = SQ_W'(d_real * d_real);
  assign sq_im_d = SQ_W'(d_imag * d_imag);

  // ---------------------------------------------------------------- stage 2
  logic [PWR_W-1:0] sum_d, sum_q;
  logic             dv2_q;
  logic [Ntag-1:0]  tag2_q;

  assign sum_d = PWR_W'(sq_re_q) + PWR_W'(sq_im_q);

  // ---------------------------------------------------------------- stage 3
  logic [Log2Navg-1:0] cnt_q;
  logic [ACC_W-1:0]    acc_d, acc_q;
  logic [Ntag-1:0]     tag_lat_q, blk_tag_d;
  logic                first_d, last_d, blk_done_d;
  logic [PWR_W-1:0]    mean_d;

  // Output-side registers.
  logic                dv_out_q, peak_valid_q, peak_valid_d;
  logic [PWR_W-1:0]    p_out_q;
  logic [Ntag-1:0]     p_tag_q;

  // Peak tracker registers.
  state_t              state_q, state_d;
  logic [PWR_W-1:0]    peak_out_q, peak_out_d;
  logic [Ntag-1:0]     peak_tag_q, peak_tag_d;
  logic [Ntag-1:0]     prev_tag_q, prev_tag_d;

  assign first_d    = (cnt_q == '0);
  assign last_d     = (cnt_q == '1);
  // The first sample of a block loads the accumulator instead of adding, so
  // no separate clear cycle is needed between blocks.
  assign acc_d      = first_d ? ACC_W'(sum_q) : (acc_q + ACC_W'(sum_q));
  assign blk_tag_d  = first_d ? tag2_q : tag_lat_q;
  assign blk_done_d = dv2_q && last_d;
  assign mean_d     = PWR_W'(acc_d >> Log2Navg);

  // The wrap decision is made one cycle early, from the tag about to be
  // published, so that peak_valid lines up with dv_out while peak_out still
  // holds the previous sweep's maximum.
  assign peak_valid_d = blk_done_d && (state_q == S_RUN) && (blk_tag_d < prev_tag_q);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dv1_q        <= 1'b0;
      sq_re_q      <= '0;
      sq_im_q      <= '0;
      tag1_q       <= '0;
      dv2_q        <= 1'b0;
      sum_q        <= '0;
      tag2_q       <= '0;
      cnt_q        <= '0;
      acc_q        <= '0;
      tag_lat_q    <= '0;
      dv_out_q     <= 1'b0;
      p_out_q      <= '0;
      p_tag_q      <= '0;
      peak_valid_q <= 1'b0;
    end else begin
      dv1_q <= dv_in;
      if (dv_in) begin
        sq_re_q <= sq_re_d;
        sq_im_q <= sq_im_d;
        tag1_q  <= tag_in;
      end

      dv2_q <= dv1_q;
      if (dv1_q) begin
        sum_q  <= sum_d;
        tag2_q <= tag1_q;
      end

      if (dv2_q) begin
        cnt_q <= cnt_q + Log2Navg'(1);   // wraps to 0 after the last sample
        acc_q <= acc_d;
        if (first_d) begin
          tag_lat_q <= tag2_q;
        end
      end

      dv_out_q     <= blk_done_d;
      peak_valid_q <= peak_valid_d;
      if (blk_done_d) begin
        p_out_q <= mean_d;
        p_tag_q <= blk_tag_d;
      end
    end
  end

  // ---------------------------------------------------------------- peak FSM
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_FIRST;
      peak_out_q <= '0;
      peak_tag_q <= '0;
      prev_tag_q <= '0;
    end else begin
      state_q    <= state_d;
      peak_out_q <= peak_out_d;
      peak_tag_q <= peak_tag_d;
      prev_tag_q <= prev_tag_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    peak_out_d = peak_out_q;
    peak_tag_d = peak_tag_q;
    prev_tag_d = prev_tag_q;
    if (dv_out_q) begin
      prev_tag_d = p_tag_q;
      case (state_q)
        S_FIRST: begin
          peak_out_d = p_out_q;
          peak_tag_d = p_tag_q;
          state_d    = S_RUN;
        end
        S_RUN: begin
          // A tag going backwards starts a new sweep, so the block restarts
          // the peak. Otherwise only a strictly larger power replaces it,
          // which keeps the earliest tag on ties.
          if ((p_tag_q < prev_tag_q) || (p_out_q > peak_out_q)) begin
            peak_out_d = p_out_q;
            peak_tag_d = p_tag_q;
          end
        end
        default: begin
          state_d = S_FIRST;
        end
      endcase
    end
  end

  assign dv_out     = dv_out_q;
  assign p_out      = p_out_q;
  assign p_tag      = p_tag_q;
  assign peak_valid = peak_valid_q;
  assign peak_out   = peak_out_q;
  assign peak_tag   = peak_tag_q;

endmodule
`default_nettype wire

// File: tb/tb_iir_power_meter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_iir_power_meter
//  Purpose  : Self-checking bench for iir_power_meter. Two instances share
//             the stimulus: A averages 4 samples, B averages 2 samples.
//  Revision : 1.0  initial release
// ============================================================================
module tb_iir_power_meter;

  typedef struct {
    int     id;
    longint p;
    int     tag;
    int     cyc;
  } blk_t;

  localparam int LG [2] = '{2, 1};

  logic        clk;
  logic        resetn;
  logic        dv_in;
  logic [17:0] d_real;
  logic [17:0] d_imag;
  logic [7:0]  tag_in;

  logic        a_dv_out, a_peak_valid, b_dv_out, b_peak_valid;
  logic [35:0] a_p_out, a_peak_out, b_p_out, b_peak_out;
  logic [7:0]  a_p_tag, a_peak_tag, b_p_tag, b_peak_tag;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_cyc = 0;
  int wide_cnt = 0;

  blk_t expQ[$], obsQ[$], pexpQ[$], pobsQ[$];

  iir_power_meter #(.Nwidth(18), .Log2Navg(2), .Ntag(8)) u_dut_a (
    .clk(clk), .resetn(resetn), .dv_in(dv_in), .d_real(d_real), .d_imag(d_imag),
    .tag_in(tag_in), .dv_out(a_dv_out), .p_out(a_p_out), .p_tag(a_p_tag),
    .peak_valid(a_peak_valid), .peak_out(a_peak_out), .peak_tag(a_peak_tag)
  );

  iir_power_meter #(.Nwidth(18), .Log2Navg(1), .Ntag(8)) u_dut_b (
    .clk(clk), .resetn(resetn), .dv_in(dv_in), .d_real(d_real), .d_imag(d_imag),
    .tag_in(tag_in), .dv_out(b_dv_out), .p_out(b_p_out), .p_tag(b_p_tag),
    .peak_valid(b_peak_valid), .peak_out(b_peak_out), .peak_tag(b_peak_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: sums whole blocks of |x|^2 and applies the sweep/peak
  // rules per completed block. cyc counts rising edges.
  longint sum_m [2];
  longint pk_m  [2];
  int     cnt_m [2];
  int     tag_m [2];
  int     prev_m[2];
  int     pkt_m [2];
  bit     first_m[2];

  initial begin
    longint pw, mean;
    forever begin
      @(posedge clk);
      if (!resetn) begin
        for (int k = 0; k < 2; k++) begin
          cnt_m[k] = 0; sum_m[k] = 0; first_m[k] = 1'b1;
          pk_m[k] = 0; pkt_m[k] = 0; prev_m[k] = 0; tag_m[k] = 0;
        end
      end else if (dv_in) begin
        pw = longint'($signed(d_real)) * longint'($signed(d_real))
           + longint'($signed(d_imag)) * longint'($signed(d_imag));
        for (int k = 0; k < 2; k++) begin
          if (cnt_m[k] == 0) begin
            sum_m[k] = 0;
            tag_m[k] = int'(tag_in);
          end
          sum_m[k] += pw;
          cnt_m[k]++;
          if (cnt_m[k] == (1 << LG[k])) begin
            mean     = sum_m[k] / longint'(1 << LG[k]);
            cnt_m[k] = 0;
            expQ.push_back('{k, mean, tag_m[k], cyc + 3});
            if (first_m[k]) begin
              first_m[k] = 1'b0;
              pk_m[k] = mean; pkt_m[k] = tag_m[k];
            end else if (tag_m[k] < prev_m[k]) begin
              pexpQ.push_back('{k, pk_m[k], pkt_m[k], cyc + 3});
              pk_m[k] = mean; pkt_m[k] = tag_m[k];
            end else if (mean > pk_m[k]) begin
              pk_m[k] = mean; pkt_m[k] = tag_m[k];
            end
            prev_m[k] = tag_m[k];
          end
        end
      end
      cyc++;
    end
  end

  // Output capture on the falling edge.
  initial begin
    bit a_last, b_last, ap_last, bp_last;
    a_last = 0; b_last = 0; ap_last = 0; bp_last = 0;
    forever begin
      @(negedge clk);
      if (a_dv_out === 1'b1)     obsQ.push_back('{0, longint'(a_p_out), int'(a_p_tag), cyc});
      if (b_dv_out === 1'b1)     obsQ.push_back('{1, longint'(b_p_out), int'(b_p_tag), cyc});
      if (a_peak_valid === 1'b1) pobsQ.push_back('{0, longint'(a_peak_out), int'(a_peak_tag), cyc});
      if (b_peak_valid === 1'b1) pobsQ.push_back('{1, longint'(b_peak_out), int'(b_peak_tag), cyc});
      if ((a_dv_out && a_last) || (b_dv_out && b_last) ||
          (a_peak_valid && ap_last) || (b_peak_valid && bp_last)) wide_cnt++;
      a_last = a_dv_out; b_last = b_dv_out; ap_last = a_peak_valid; bp_last = b_peak_valid;
    end
  end

  // ------------------------------------------------------------ stimulus
  task automatic send(input int re, input int im, input int tg, input int gap);
    @(negedge clk);
    dv_in    = 1'b1;
    d_real   = re[17:0];
    d_imag   = im[17:0];
    tag_in   = tg[7:0];
    last_cyc = cyc;
    repeat (gap) begin
      @(negedge clk);
      dv_in = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    dv_in = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    dv_in  = 1'b0;
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  // ------------------------------------------------------------ tests
  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({a_dv_out, a_p_out, a_p_tag, a_peak_valid, a_peak_out, a_peak_tag} !== '0) begin
      failures++;
      $display("FAIL reset_A: dv=%b p=%0d tag=%0d pv=%b pk=%0d pkt=%0d, all required 0",
               a_dv_out, a_p_out, a_p_tag, a_peak_valid, a_peak_out, a_peak_tag);
    end
    checks++;
    if ({b_dv_out, b_p_out, b_p_tag, b_peak_valid, b_peak_out, b_peak_tag} !== '0) begin
      failures++;
      $display("FAIL reset_B: dv=%b p=%0d tag=%0d pv=%b pk=%0d pkt=%0d, all required 0",
               b_dv_out, b_p_out, b_p_tag, b_peak_valid, b_peak_out, b_peak_tag);
    end
    resetn = 1'b1;
  endtask

  task automatic test_gapped();
    blk_t o[$];
    int   lc[2];
    int   base;
    apply_reset();
    base = obsQ.size();
    for (int i = 0; i < 8; i++) begin
      send(100, 0, 5, 6);
      if (i == 3) lc[0] = last_cyc;
      if (i == 7) lc[1] = last_cyc;
    end
    idle(8);
    for (int i = base; i < obsQ.size(); i++) if (obsQ[i].id == 0) o.push_back(obsQ[i]);
    checks++;
    if (o.size() != 2) begin
      failures++;
      $display("FAIL gapped_count: got %0d blocks, required 2", o.size());
    end
    for (int j = 0; j < 2 && j < o.size(); j++) begin
      checks++;
      if (o[j].p !== 64'd10000 || o[j].tag !== 5 || o[j].cyc !== lc[j] + 3) begin
        failures++;
        $display("FAIL gapped_blk%0d: p=%0d tag=%0d cyc=%0d, required p=10000 tag=5 cyc=%0d",
                 j, o[j].p, o[j].tag, o[j].cyc, lc[j] + 3);
      end
    end
  endtask

  task automatic test_full_scale();
    blk_t o[$];
    int   base;
    apply_reset();
    base = obsQ.size();
    for (int i = 0; i < 4; i++) send(-131072, -131072, 9, 0);
    idle(8);
    for (int i = base; i < obsQ.size(); i++) if (obsQ[i].id == 0) o.push_back(obsQ[i]);
    checks++;
    if (o.size() != 1) begin
      failures++;
      $display("FAIL fullscale_count: got %0d blocks, required 1", o.size());
    end else begin
      checks++;
      if (o[0].p !== 64'd34359738368 || o[0].tag !== 9 || o[0].cyc !== last_cyc + 3) begin
        failures++;
        $display("FAIL fullscale_blk: p=%0d tag=%0d cyc=%0d, required p=34359738368 tag=9 cyc=%0d",
                 o[0].p, o[0].tag, o[0].cyc, last_cyc + 3);
      end
    end
  endtask

  task automatic test_truncate();
    blk_t o[$];
    int   base;
    int   re[4] = '{3, 4, 0, 1};
    int   im[4] = '{0, 0, 5, 1};
    apply_reset();
    base = obsQ.size();
    for (int i = 0; i < 4; i++) send(re[i], im[i], 7, 1);
    idle(8);
    for (int i = base; i < obsQ.size(); i++) if (obsQ[i].id == 0) o.push_back(obsQ[i]);
    checks++;
    if (o.size() != 1 || o[0].p !== 64'd13 || o[0].tag !== 7) begin
      failures++;
      $display("FAIL truncate_mean: blocks=%0d p=%0d tag=%0d, required 1 block p=13 tag=7",
               o.size(), (o.size() > 0) ? o[0].p : -1, (o.size() > 0) ? o[0].tag : -1);
    end
  endtask

  task automatic test_peak_sweep();
    blk_t o[$], pk[$];
    int   ob, pb;
    int   re[10] = '{5, 5, 20, 10, 20, 10, 10, 10, 3, 2};
    int   im[10] = '{5, 5,  0, 10,  0, 10,  0,  0, 0, 1};
    int   tg[5]  = '{10, 20, 30, 40, 2};
    apply_reset();
    ob = obsQ.size();
    pb = pobsQ.size();
    for (int i = 0; i < 10; i++) send(re[i], im[i], tg[i/2], 1);
    idle(8);
    for (int i = ob; i < obsQ.size(); i++)  if (obsQ[i].id == 1)  o.push_back(obsQ[i]);
    for (int i = pb; i < pobsQ.size(); i++) if (pobsQ[i].id == 1) pk.push_back(pobsQ[i]);
    checks++;
    if (o.size() != 5 || o[o.size()-1].p !== 64'd7 || o[o.size()-1].tag !== 2) begin
      failures++;
      $display("FAIL peak_blocks: blocks=%0d, required 5 ending p=7 tag=2", o.size());
    end
    checks++;
    if (pk.size() != 1) begin
      failures++;
      $display("FAIL peak_event_count: got %0d, required 1", pk.size());
    end else begin
      checks++;
      if (pk[0].p !== 64'd300 || pk[0].tag !== 20) begin
        failures++;
        $display("FAIL peak_event_value: peak=%0d tag=%0d, required peak=300 tag=20", pk[0].p, pk[0].tag);
      end
      checks++;
      if (o.size() == 5 && pk[0].cyc !== o[4].cyc) begin
        failures++;
        $display("FAIL peak_event_align: peak_valid cyc=%0d, required dv_out cyc=%0d", pk[0].cyc, o[4].cyc);
      end
    end
    checks++;
    if (b_peak_out !== 36'd7 || b_peak_tag !== 8'd2) begin
      failures++;
      $display("FAIL peak_after_wrap: peak=%0d tag=%0d, required peak=7 tag=2", b_peak_out, b_peak_tag);
    end
  endtask

  task automatic test_reset_mid();
    blk_t o[$];
    int   base;
    apply_reset();
    base = obsQ.size();
    send(10, 0, 3, 1);
    send(10, 0, 3, 0);
    resetn = 1'b0;
    dv_in  = 1'b1;
    @(negedge clk);
    d_real = 18'd50;
    @(negedge clk);
    checks++;
    if ({a_dv_out, a_p_out, a_p_tag, a_peak_valid, a_peak_out, a_peak_tag} !== '0) begin
      failures++;
      $display("FAIL midreset_outputs: dv=%b p=%0d tag=%0d pv=%b pk=%0d, all required 0",
               a_dv_out, a_p_out, a_p_tag, a_peak_valid, a_peak_out);
    end
    dv_in  = 1'b0;
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) send(10, 0, 4, 2);
    idle(8);
    for (int i = base; i < obsQ.size(); i++) if (obsQ[i].id == 0) o.push_back(obsQ[i]);
    checks++;
    if (o.size() != 1 || o[0].p !== 64'd100 || o[0].tag !== 4) begin
      failures++;
      $display("FAIL midreset_block: blocks=%0d p=%0d, required 1 block p=100 tag=4",
               o.size(), (o.size() > 0) ? o[0].p : -1);
    end
  endtask

  task automatic test_random();
    blk_t e[$], o[$];
    int   eb, ob, peb, pob, tg;
    apply_reset();
    eb = expQ.size(); ob = obsQ.size(); peb = pexpQ.size(); pob = pobsQ.size();
    tg = 0;
    for (int i = 0; i < 240; i++) begin
      // Tag 0 for the whole first block, then a slowly rising sweep that
      // occasionally restarts low.
      if (i >= 4) begin
        if ($urandom_range(0, 30) == 0) tg = $urandom_range(0, 15);
        else tg = (tg + $urandom_range(0, 3)) % 256;
      end
      send(int'($urandom_range(0, 262143)) - 131072,
           int'($urandom_range(0, 262143)) - 131072, tg, $urandom_range(0, 3));
    end
    idle(10);
    for (int k = 0; k < 2; k++) begin
      e.delete(); o.delete();
      for (int i = eb; i < expQ.size(); i++) if (expQ[i].id == k) e.push_back(expQ[i]);
      for (int i = ob; i < obsQ.size(); i++) if (obsQ[i].id == k) o.push_back(obsQ[i]);
      checks++;
      if (o.size() != e.size()) begin
        failures++;
        $display("FAIL rand_count_%0d: got %0d blocks, required %0d", k, o.size(), e.size());
      end
      for (int i = 0; i < e.size() && i < o.size(); i++) begin
        checks++;
        if (o[i].p !== e[i].p || o[i].tag !== e[i].tag || o[i].cyc !== e[i].cyc) begin
          failures++;
          $display("FAIL rand_blk_%0d_%0d: p=%0d tag=%0d cyc=%0d, required p=%0d tag=%0d cyc=%0d",
                   k, i, o[i].p, o[i].tag, o[i].cyc, e[i].p, e[i].tag, e[i].cyc);
        end
      end
      e.delete(); o.delete();
      for (int i = peb; i < pexpQ.size(); i++) if (pexpQ[i].id == k) e.push_back(pexpQ[i]);
      for (int i = pob; i < pobsQ.size(); i++) if (pobsQ[i].id == k) o.push_back(pobsQ[i]);
      checks++;
      if (o.size() != e.size()) begin
        failures++;
        $display("FAIL rand_peak_count_%0d: got %0d events, required %0d", k, o.size(), e.size());
      end
      for (int i = 0; i < e.size() && i < o.size(); i++) begin
        checks++;
        if (o[i].p !== e[i].p || o[i].tag !== e[i].tag || o[i].cyc !== e[i].cyc) begin
          failures++;
          $display("FAIL rand_peak_%0d_%0d: peak=%0d tag=%0d cyc=%0d, required peak=%0d tag=%0d cyc=%0d",
                   k, i, o[i].p, o[i].tag, o[i].cyc, e[i].p, e[i].tag, e[i].cyc);
        end
      end
    end
    checks++;
    if (longint'(a_peak_out) !== pk_m[0] || int'(a_peak_tag) !== pkt_m[0]) begin
      failures++;
      $display("FAIL rand_final_peak_A: peak=%0d tag=%0d, required peak=%0d tag=%0d",
               a_peak_out, a_peak_tag, pk_m[0], pkt_m[0]);
    end
    checks++;
    if (longint'(b_peak_out) !== pk_m[1] || int'(b_peak_tag) !== pkt_m[1]) begin
      failures++;
      $display("FAIL rand_final_peak_B: peak=%0d tag=%0d, required peak=%0d tag=%0d",
               b_peak_out, b_peak_tag, pk_m[1], pkt_m[1]);
    end
    checks++;
    if (wide_cnt != 0) begin
      failures++;
      $display("FAIL pulse_width: %0d pulses wider than 1 cycle, required 0", wide_cnt);
    end
  endtask

  initial begin
    resetn = 1'b0;
    dv_in  = 1'b0;
    d_real = '0;
    d_imag = '0;
    tag_in = '0;
    repeat (3) @(negedge clk);
    test_reset();
    test_gapped();
    test_full_scale();
    test_truncate();
    test_peak_sweep();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
